// File: rtl/axis_cobs_packet_arbiter.sv
// ---------------------------------------------------------------------------
// axis_cobs_packet_arbiter
//
// Purpose
//   Packet-granular round-robin arbiter that lets NUM_PORTS AXI-Stream byte
//   producers share one downstream COBS encoder chain. A grant is taken in
//   IDLE (one cycle of arbitration) and held from the first beat until the
//   beat carrying tlast has transferred, so packets are never interleaved.
//   The datapath is a pure combinational mux: no buffering, no extra latency
//   once a grant is held.
//
// Optional feature (macro SOURCE_ID_HEADER_EN)
//   When defined, each granted packet is preceded by one header byte holding
//   the granted port index, so the far end can demultiplex after COBS decode.
//   When undefined, payload bytes pass through unmodified.
//
// Ports
//   clk       in   shared clock for every stream
//   reset     in   synchronous, active-high
//   s_tdata   in   NUM_PORTS*8   port i byte at [8*i+7:8*i]
//   s_tvalid  in   NUM_PORTS     per-port valid
//   s_tlast   in   NUM_PORTS     per-port end of packet
//   s_tready  out  NUM_PORTS     per-port ready (only the granted port in PASS)
//   m_tdata   out  8             to encoder sink
//   m_tvalid  out  1
//   m_tlast   out  1
//   m_tready  in   1
//   busy      out  1             high while a grant is held
//   grant_id  out  GRANT_W       port currently granted / last granted
// ---------------------------------------------------------------------------
module axis_cobs_packet_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int GRANT_W   = $clog2(NUM_PORTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS*8-1:0] s_tdata,
    input  logic [NUM_PORTS-1:0]   s_tvalid,
    input  logic [NUM_PORTS-1:0]   s_tlast,
    output logic [NUM_PORTS-1:0]   s_tready,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    output logic                   m_tlast,
    input  logic                   m_tready,
    output logic                   busy,
    output logic [GRANT_W-1:0]     grant_id
);

    localparam logic [1:0] ST_IDLE = 2'd0;
`ifdef SOURCE_ID_HEADER_EN
    localparam logic [1:0] ST_HDR  = 2'd1;
`endif
    localparam logic [1:0] ST_PASS = 2'd2;

    localparam logic [GRANT_W:0] NP = (GRANT_W+1)'(NUM_PORTS);

    logic [1:0]         state_q, state_d;
    // Doubles as last_grant: it only changes when a new grant is issued.
    logic [GRANT_W-1:0] grant_q, grant_d;

    logic [7:0]         port_data [NUM_PORTS];
    logic               found;
    logic [GRANT_W-1:0] winner;
    logic [GRANT_W:0]   cand;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_data[gi] = s_tdata[8*gi +: 8];
            assign s_tready[gi]  = (state_q == ST_PASS) &&
                                   (grant_q == GRANT_W'(gi)) && m_tready;
        end
    endgenerate

    // Round-robin search starting just after the last grant, wrapping.
    // The last candidate (k == NUM_PORTS) is the previous winner itself.
    always_comb begin
        found  = 1'b0;
        winner = grant_q;
        cand   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = (GRANT_W+1)'(grant_q) + (GRANT_W+1)'(k);
            if (cand >= NP) begin
                cand = cand - NP;
            end
            if (!found && s_tvalid[cand[GRANT_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[GRANT_W-1:0];
            end
        end
    end

    always_comb begin
        m_tdata  = 8'h00;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        state_d  = state_q;
        grant_d  = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = winner;
`ifdef SOURCE_ID_HEADER_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_PASS;
`endif
                end
            end
`ifdef SOURCE_ID_HEADER_EN
            ST_HDR: begin
                m_tvalid = 1'b1;
                m_tdata  = {{(8-GRANT_W){1'b0}}, grant_q};
                if (m_tready) begin
                    state_d = ST_PASS;
                end
            end
`endif
            ST_PASS: begin
                m_tdata  = port_data[grant_q];
                m_tvalid = s_tvalid[grant_q];
                m_tlast  = s_tlast[grant_q];
                if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= GRANT_W'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign grant_id = grant_q;

endmodule

// File: tb/tb_axis_cobs_packet_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_cobs_packet_arbiter
//
// Self-checking bench for axis_cobs_packet_arbiter with NUM_PORTS = 4.
// Single-beat-per-cycle vectors are kept in a table; multi-cycle scenarios
// (ready toggling, round-robin refill, reset mid-packet, header byte) are
// written out as short sequences. Inputs change on the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_axis_cobs_packet_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic [1:0]  grant_id;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_cobs_packet_arbiter #(.NUM_PORTS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .busy     (busy),
        .grant_id (grant_id)
    );

    typedef struct {
        logic [3:0]  vld;
        logic [3:0]  lst;
        logic [31:0] data;
        logic        rdy;
        logic        e_mvalid;
        logic [7:0]  e_mdata;
        logic        e_mlast;
        logic [3:0]  e_sready;
        logic        e_busy;
        logic [1:0]  e_gid;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [7:0] ed,
                           input logic el, input logic [3:0] er, input logic eb,
                           input logic [1:0] eg);
        chk({tag, ".m_tvalid"}, 32'(m_tvalid), 32'(ev));
        chk({tag, ".m_tdata"},  32'(m_tdata),  32'(ed));
        chk({tag, ".m_tlast"},  32'(m_tlast),  32'(el));
        chk({tag, ".s_tready"}, 32'(s_tready), 32'(er));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(eg));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all("reset", 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd3);
    endtask

    // Round-robin refill model: port p presents {p, count}, tlast on odd count.
    int cnt [4];
    task automatic drive_rr(input logic [3:0] vld);
        s_tvalid = vld;
        for (int p = 0; p < 4; p++) begin
            s_tdata[8*p +: 8] = {4'(p), 4'(cnt[p])};
            s_tlast[p]        = cnt[p][0];
        end
    endtask

    initial begin
        reset    = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        m_tready = 1'b0;

        // Test 1: port 0 three-byte packet, then test 4: port 3 single byte
        // followed by port 1.
        //          vld      lst      data          rdy  mv  md     ml  srdy     busy gid
        vecs[0] = '{4'b0001, 4'b0000, 32'h00000011, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd3};
        vecs[1] = '{4'b0001, 4'b0000, 32'h00000011, 1, 1, 8'h11, 0, 4'b0001, 1, 2'd0};
        vecs[2] = '{4'b0001, 4'b0000, 32'h00000022, 1, 1, 8'h22, 0, 4'b0001, 1, 2'd0};
        vecs[3] = '{4'b0001, 4'b0001, 32'h00000033, 1, 1, 8'h33, 1, 4'b0001, 1, 2'd0};
        vecs[4] = '{4'b1000, 4'b1000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd0};
        vecs[5] = '{4'b1010, 4'b1000, 32'h00005500, 1, 1, 8'h00, 1, 4'b1000, 1, 2'd3};
        vecs[6] = '{4'b0010, 4'b0010, 32'h00005500, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd3};
        vecs[7] = '{4'b0010, 4'b0010, 32'h00005500, 1, 1, 8'h55, 1, 4'b0010, 1, 2'd1};
        vecs[8] = '{4'b0000, 4'b0000, 32'h00000000, 1, 0, 8'h00, 0, 4'b0000, 0, 2'd1};
        vecs[9] = '{4'b0000, 4'b0000, 32'h00000000, 0, 0, 8'h00, 0, 4'b0000, 0, 2'd1};

        do_reset();

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s_tvalid = vecs[i].vld;
            s_tlast  = vecs[i].lst;
            s_tdata  = vecs[i].data;
            m_tready = vecs[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].e_mvalid, vecs[i].e_mdata,
                    vecs[i].e_mlast, vecs[i].e_sready, vecs[i].e_busy, vecs[i].e_gid);
        end

        // Test 3: port 1 eight-byte packet with m_tready toggling 1,0,1,0...
        begin
            int idx = 0;
            int cyc = 0;
            @(negedge clk);
            s_tvalid = 4'b0010;
            s_tlast  = 4'b0000;
            s_tdata  = {16'h0, 8'h80, 8'h0};
            m_tready = 1'b1;
            #1;
            chk("t3.arb_cycle_valid", 32'(m_tvalid), 32'd0);
            while (idx < 8 && cyc < 40) begin
                @(negedge clk);
                m_tready = (cyc % 2 == 0);
                s_tdata  = {16'h0, 8'(8'h80 + idx), 8'h0};
                s_tlast  = (idx == 7) ? 4'b0010 : 4'b0000;
                #1;
                chk($sformatf("t3.c%0d.m_tvalid", cyc), 32'(m_tvalid), 32'd1);
                chk($sformatf("t3.c%0d.m_tdata", cyc), 32'(m_tdata), 32'(8'h80 + idx));
                chk($sformatf("t3.c%0d.m_tlast", cyc), 32'(m_tlast), 32'(idx == 7));
                chk($sformatf("t3.c%0d.s_tready", cyc), 32'(s_tready),
                    32'({2'b00, m_tready, 1'b0}));
                if (m_tready) idx++;
                cyc++;
            end
            chk("t3.bytes_sent", 32'(idx), 32'd8);
            @(negedge clk);
            s_tvalid = '0;
            s_tlast  = '0;
            m_tready = 1'b1;
            #1;
            chk("t3.idle_after.busy", 32'(busy), 32'd0);
        end

        // Test 2: ports 0 and 2 always valid, 2-byte packets -> 0,2,0,2.
        do_reset();
        for (int p = 0; p < 4; p++) cnt[p] = 0;
        for (int pkt = 0; pkt < 4; pkt++) begin
            int p;
            p = (pkt % 2 == 1) ? 2 : 0;
            @(negedge clk);
            drive_rr(4'b0101);
            #1;
            chk($sformatf("t2.pkt%0d.idle_valid", pkt), 32'(m_tvalid), 32'd0);
            chk($sformatf("t2.pkt%0d.idle_busy", pkt), 32'(busy), 32'd0);
            for (int b = 0; b < 2; b++) begin
                @(negedge clk);
                drive_rr(4'b0101);
                #1;
                chk($sformatf("t2.pkt%0d.b%0d.grant", pkt, b), 32'(grant_id), 32'(p));
                chk($sformatf("t2.pkt%0d.b%0d.m_tvalid", pkt, b), 32'(m_tvalid), 32'd1);
                chk($sformatf("t2.pkt%0d.b%0d.m_tdata", pkt, b), 32'(m_tdata),
                    32'({4'(p), 4'(2*(pkt/2) + b)}));
                chk($sformatf("t2.pkt%0d.b%0d.m_tlast", pkt, b), 32'(m_tlast), 32'(b == 1));
                chk($sformatf("t2.pkt%0d.b%0d.s_tready", pkt, b), 32'(s_tready),
                    32'(4'b0001 << p));
                cnt[p]++;
            end
        end

        // Test 5: reset during beat 2 of a 4-byte packet on port 2.
        @(negedge clk);
        s_tvalid = 4'b0100;
        s_tlast  = 4'b0000;
        s_tdata  = 32'h00C00000;
        #1;
        chk("t5.arb.m_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        #1;
        chk("t5.beat1.m_tdata", 32'(m_tdata), 32'hC0);
        @(negedge clk);
        s_tdata = 32'h00C10000;
        reset   = 1'b1;
        #1;
        chk("t5.beat2.m_tdata", 32'(m_tdata), 32'hC1);
        @(negedge clk);
        reset    = 1'b0;
        s_tvalid = 4'b0101;
        s_tlast  = 4'b0001;
        s_tdata  = 32'h00C2000A;
        #1;
        chk_all("t5.after_reset", 1'b0, 8'h00, 1'b0, 4'b0000, 1'b0, 2'd3);
        @(negedge clk);
        #1;
        chk_all("t5.regrant", 1'b1, 8'h0A, 1'b1, 4'b0001, 1'b1, 2'd0);

`ifdef SOURCE_ID_HEADER_EN
        // Test 6: header byte carries the source index, held while stalled.
        do_reset();
        @(negedge clk);
        s_tvalid = 4'b1000;
        s_tlast  = 4'b1000;
        s_tdata  = 32'hAA000000;
        m_tready = 1'b0;
        #1;
        chk("t6.arb.m_tvalid", 32'(m_tvalid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk_all($sformatf("t6.hdr_stall%0d", i), 1'b1, 8'h03, 1'b0, 4'b0000, 1'b1, 2'd3);
        end
        @(negedge clk);
        m_tready = 1'b1;
        #1;
        chk_all("t6.hdr_xfer", 1'b1, 8'h03, 1'b0, 4'b0000, 1'b1, 2'd3);
        @(negedge clk);
        #1;
        chk_all("t6.payload", 1'b1, 8'hAA, 1'b1, 4'b1000, 1'b1, 2'd3);
`endif

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
